register_file_8x32: RTL and testbench
=====================================

// Module: register_file_8x32
// PURPOSE
//   Eight-entry x 32-bit register file: one synchronous write port, one
//   asynchronous (combinational) read port. General-purpose datapath storage.
//   Built as 8 enable-gated 32-bit registers, a 3-to-8 write-enable decoder
//   and an 8-to-1 x 32-bit read multiplexer.
// PARAMETERS
//   DATA_WIDTH  32  width of each register, wData and rData
//   ADDR_WIDTH  3   width of wAddr/rAddr; depth = 2**ADDR_WIDTH = 8
// PORTS
//   clk      in   1   single clock; all state updates on rising edge
//   reset_n  in   1   reset, synchronous and active-low
//   we       in   1   write enable, active-high
//   wAddr    in   3   write address, 0..7
//   rAddr    in   3   read address, 0..7
//   wData    in   32  write data
//   rData    out  32  read data = contents of register[rAddr]
// BEHAVIOUR
// - One clock (clk), rising-edge triggered. No other clocks or latches.
// - Reset:
//   - reset_n sampled only at rising edge of clk (synchronous, active-low).
//   - reset_n==0 at an edge clears all 8 registers to 32'h00000000.
//   - Reset has priority over we; no write occurs in that cycle.
//   - Until the first reset edge, register contents are undefined (X in sim).
//   - Reset asserted mid-operation clears everything at the next edge;
//     rData then follows the cleared value combinationally.
// - Write:
//   - At rising edge with reset_n==1 and we==1, register[wAddr] <= wData.
//   - All other registers hold their values.
//   - we==0: no register changes.
//   - Decoder produces a one-hot enable (exactly one bit high when we==1,
//     all zero when we==0).
// - Read:
//   - rData = register[rAddr], purely combinational, zero cycle latency.
//   - rData changes when rAddr changes or when the addressed register updates.
// - Read-during-write to the same address:
//   - No bypass; rData shows the old value before the edge, the new value
//     after it.
// - All address values 0..7 are valid. There is no out-of-range case and
//   no wrap logic needed.
// - No handshake, no stall and no error outputs.
// TESTING
// 1. Hold reset_n=0 across one edge, then rAddr=0..7 -> rData=32'h00000000
//    for every address.
// 2. reset_n=1, we=1, wAddr=0, wData=32'h11111111, with rAddr=0:
//    - rData stays 0 until the edge, then reads 32'h11111111.
// 3. Write wAddr=1 and wAddr=2 with 32'hFF00FF00, then wAddr=3 with
//    32'h00FF00FF; set we=0; read rAddr=1,2,3:
//    -> FF00FF00, FF00FF00, 00FF00FF. rAddr=4..7 still read 0.
// 4. we=0, wAddr=0, wData=32'hDEADBEEF over several edges:
//    -> rAddr=0 still reads 32'h11111111 (no write).
// 5. Load all 8 registers with distinct values (e.g. 32'hA0000000+i):
//    -> each address reads back its own value; no aliasing between entries.
// 6. Assert reset_n=0 together with we=1, wAddr=5, wData=32'h12345678
//    for one edge:
//    -> all registers read 0, including address 5 (reset wins).

Source files
------------

// File: rtl/register_file_8x32.sv
// register_file_8x32
//   Eight-entry x 32-bit register file for general-purpose datapath storage.
//   It has one synchronous write port and one combinational read port.
//   Storage is eight enable-gated registers. A one-hot decoder drives the
//   write enables, and an 8-to-1 multiplexer drives the read port.
//
// Ports
//   clk      in   1           rising-edge clock for all state
//   reset_n  in   1           synchronous active-low reset; clears every entry
//   we       in   1           write enable, active-high
//   wAddr    in   ADDR_WIDTH  write address
//   rAddr    in   ADDR_WIDTH  read address
//   wData    in   DATA_WIDTH  write data
//   rData    out  DATA_WIDTH  contents of entry rAddr (zero latency, no bypass)
module register_file_8x32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  output logic [DATA_WIDTH-1:0] rData
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [DATA_WIDTH-1:0] regs_d [Depth];
  logic [Depth-1:0]      wr_en;

  // One-hot write-enable decoder; all zero when we is low.
  always_comb begin
    wr_en = '0;
    if (we) begin
      wr_en[wAddr] = 1'b1;
    end
  end

  // Reset takes priority over any write in the same cycle.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      regs_d[i] = regs_q[i];
      if (!reset_n) begin
        regs_d[i] = '0;
      end else if (wr_en[i]) begin
        regs_d[i] = wData;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < Depth; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Read port has no bypass, so a same-address write is visible only after the edge.
  always_comb begin
    rData = regs_q[rAddr];
  end

endmodule

// File: tb/tb_register_file_8x32.sv
// Scoreboard bench for register_file_8x32. The stimulus side drives inputs
// 1 ns after each rising edge. It then pushes the read value expected from
// a simple array model, taken from the state before the coming edge. A
// separate monitor pops one expectation at each falling edge and compares
// it against rData.
module tb_register_file_8x32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  wAddr = '0;
  logic [2:0]  rAddr = '0;
  logic [31:0] wData = '0;
  logic [31:0] rData;

  register_file_8x32 dut (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .wAddr  (wAddr),
    .rAddr  (rAddr),
    .wData  (wData),
    .rData  (rData)
  );

  always #5 clk = ~clk;

  // Reference model: plain array, known once the first reset edge has passed.
  logic [31:0] model [8];
  bit          model_known = 1'b0;

  logic [31:0] exp_q  [$];
  string       name_q [$];

  int total = 0;
  int bad   = 0;

  // Monitor: the read port is always presenting data, so sample once per cycle
  // at the falling edge whenever an expectation is pending.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (rData !== e) begin
          bad++;
          $display("FAIL %s: rData=%h expected=%h", n, rData, e);
        end
      end
    end
  end

  // Apply the edge that just happened to the model (using the inputs that were
  // held across it), then drive the next cycle and queue its expected read.
  task automatic cyc(input bit rst_n, input bit w, input logic [2:0] wa,
                     input logic [2:0] ra, input logic [31:0] wd, input string nm);
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) model[i] = 32'h0;
      model_known = 1'b1;
    end else if (we) begin
      model[wAddr] = wData;
    end
    #1;
    reset_n = rst_n;
    we      = w;
    wAddr   = wa;
    rAddr   = ra;
    wData   = wd;
    if (model_known) begin
      exp_q.push_back(model[ra]);
      name_q.push_back(nm);
    end
  endtask

  initial begin
    int waited;
    // 1: reset for one edge, then read every address.
    cyc(1'b0, 1'b0, 3'd0, 3'd0, 32'h0, "reset_hold");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'd0, 3'(i), 32'h0, "reset_read");

    // 2: write 0 while reading 0; old value before the edge, new after.
    cyc(1'b1, 1'b1, 3'd0, 3'd0, 32'h11111111, "rdw_old");
    cyc(1'b1, 1'b0, 3'd0, 3'd0, 32'h0, "rdw_new");

    // 3: patterned writes, then reads including untouched entries.
    cyc(1'b1, 1'b1, 3'd1, 3'd0, 32'hFF00FF00, "wr1");
    cyc(1'b1, 1'b1, 3'd2, 3'd1, 32'hFF00FF00, "wr2");
    cyc(1'b1, 1'b1, 3'd3, 3'd2, 32'h00FF00FF, "wr3");
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, 3'd0, 3'(i), 32'h0, "pattern_read");

    // 4: we low with live data must not write.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'd0, 3'd0, 32'hDEADBEEF, "no_write");

    // 5: distinct value per entry, then read back all.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), 3'(7 - i), 32'hA0000000 + i, "fill");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'd0, 3'(i), 32'h0, "alias_read");

    // 6: reset together with a write; reset wins.
    cyc(1'b0, 1'b1, 3'd5, 3'd5, 32'h12345678, "rst_vs_we");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'd5, 3'(i), 32'h0, "post_rst_read");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) != 0), 1'($urandom), 3'($urandom), 3'($urandom),
          $urandom, "random");
    end
    cyc(1'b1, 1'b0, 3'd0, 3'd0, 32'h0, "final");

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
